instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 86 ++++++++
 tb/tb_instr_fetch_unit.sv | 89 ++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, single-outstanding imem req/ack, valid/ready handoff to decode
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        branch_en_in,
  input  logic [31:0] branch_target_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_r15_out
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HOLD} state_t;
  state_t      state_q;
  logic [31:0] fetch_pc_q, addr_q, instr_q, pc_q, pc_r15_q;
  logic        req_q, valid_q;
  logic [31:0] tgt;
  assign tgt = {branch_target_in[31:2], 2'b00};
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_r15_q   <= 32'd8;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_q  <= branch_en_in ? tgt : fetch_pc_q;
          req_q   <= 1'b1;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack_in && branch_en_in) begin
            addr_q     <= tgt;
            fetch_pc_q <= tgt;
          end else if (imem_ack_in) begin
            instr_q    <= imem_data_in;
            pc_q       <= addr_q;
            pc_r15_q   <= addr_q + 32'd8;
            fetch_pc_q <= addr_q + 32'd4;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= S_HOLD;
          end else if (branch_en_in) begin
            fetch_pc_q <= tgt;
            state_q    <= S_DROP;
          end
        end
        S_DROP: begin
          // the stale request stays on the bus until acked; the latest target wins
          if (branch_en_in) fetch_pc_q <= tgt;
          if (imem_ack_in) begin
            addr_q  <= branch_en_in ? tgt : fetch_pc_q;
            state_q <= S_REQ;
          end
        end
        S_HOLD: begin
          if (branch_en_in || instr_ready_in) begin
            addr_q  <= branch_en_in ? tgt : fetch_pc_q;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
          if (branch_en_in) fetch_pc_q <= tgt;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign imem_req_out    = req_q;
  assign imem_addr_out   = addr_q;
  assign instr_valid_out = valid_q;
  assign instr_out       = instr_q;
  assign pc_out          = pc_q;
  assign pc_r15_out      = pc_r15_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch sequencing, stalls, redirects, wrap and async reset
module tb_instr_fetch_unit;
  logic        clk = 0, rst_n = 0, br = 0, ack = 0, rdy = 0;
  logic [31:0] tgt = 0, data = 0;
  logic        req0, val0, req1, val1;
  logic [31:0] addr0, ins0, pc0, r150, addr1, ins1, pc1, r151;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .branch_en_in(br), .branch_target_in(tgt),
    .imem_req_out(req0), .imem_addr_out(addr0), .imem_ack_in(ack), .imem_data_in(data),
    .instr_valid_out(val0), .instr_ready_in(rdy), .instr_out(ins0), .pc_out(pc0), .pc_r15_out(r150));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .branch_en_in(br), .branch_target_in(tgt),
    .imem_req_out(req1), .imem_addr_out(addr1), .imem_ack_in(ack), .imem_data_in(data),
    .instr_valid_out(val1), .instr_ready_in(rdy), .instr_out(ins1), .pc_out(pc1), .pc_r15_out(r151));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_req", req0, 0); chk("rst_val", val0, 0); chk("rst_addr", addr0, 32'h100);
    chk("rst_ins", ins0, 0); chk("rst_pc", pc0, 0); chk("rst_r15", r150, 8);
    chk("rst_addr_u1", addr1, 32'hFFFF_FFFC);
    cyc(); #2 rst_n = 1; #1;
    chk("idle_req", req0, 0);
    cyc(); chk("req0_up", req0, 1); chk("req0_addr", addr0, 32'h100);
    ack = 1; data = 32'hA000_0000; rdy = 1;
    cyc(); chk("i0_val", val0, 1); chk("i0_ins", ins0, 32'hA000_0000);
    chk("i0_pc", pc0, 32'h100); chk("i0_r15", r150, 32'h108); chk("i0_req", req0, 0);
    cyc(); chk("req1_addr", addr0, 32'h104); chk("req1_val", val0, 0); chk("req1_req", req0, 1);
    data = 32'hA000_0001;
    cyc(); chk("i1_pc", pc0, 32'h104); chk("i1_ins", ins0, 32'hA000_0001);
    ack = 0;
    cyc(); chk("req2_addr", addr0, 32'h108);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("wait_addr", addr0, 32'h108); chk("wait_req", req0, 1);
    end
    ack = 1; data = 32'hA000_0002;
    cyc(); ack = 0; chk("i2_val", val0, 1); chk("i2_pc", pc0, 32'h108);
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("bp_val", val0, 1); chk("bp_ins", ins0, 32'hA000_0002); chk("bp_pc", pc0, 32'h108);
    end
    rdy = 1;
    cyc(); chk("req3_addr", addr0, 32'h10C); chk("req3_val", val0, 0);
    br = 1; tgt = 32'h2000;
    cyc(); br = 0; chk("drop_addr", addr0, 32'h10C); chk("drop_req", req0, 1);
    cyc(); chk("drop_hold", addr0, 32'h10C);
    ack = 1; data = 32'hDEAD_BEEF;
    cyc(); chk("tgt_addr", addr0, 32'h2000); chk("stale_val", val0, 0);
    data = 32'hB000_0000;
    cyc(); chk("b0_ins", ins0, 32'hB000_0000); chk("b0_pc", pc0, 32'h2000); chk("b0_r15", r150, 32'h2008);
    cyc(); chk("req_2004", addr0, 32'h2004);
    br = 1; tgt = 32'h43; data = 32'hC000_0000;
    cyc(); br = 0; chk("coin_addr", addr0, 32'h40); chk("coin_val", val0, 0); chk("coin_req", req0, 1);
    data = 32'hC000_0001;
    cyc(); chk("c1_pc", pc0, 32'h40); chk("c1_ins", ins0, 32'hC000_0001);
    br = 1; tgt = 32'h40; ack = 0;
    cyc(); br = 0; chk("hold_br_addr", addr0, 32'h40); chk("hold_br_val", val0, 0);
    ack = 1; data = 32'hC000_0002;
    cyc(); chk("c2_ins", ins0, 32'hC000_0002); chk("c2_pc", pc0, 32'h40);
    ack = 0;
    cyc(); chk("req_44", addr0, 32'h44);
    br = 1; tgt = 32'h3000;
    cyc(); tgt = 32'h5000; ack = 1;
    cyc(); br = 0; ack = 0; chk("last_br_wins", addr0, 32'h5000); chk("lbw_val", val0, 0);
    chk("pre_rst_req", req0, 1);
    #2 rst_n = 0; #1;
    chk("async_req", req0, 0); chk("async_val", val0, 0); chk("async_addr", addr0, 32'h100);
    #1 rst_n = 1; rdy = 0;
    cyc(); chk("restart_addr", addr0, 32'h100); chk("wrap_req", req1, 1); chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
    ack = 1; data = 32'hE000_0000;
    cyc(); ack = 0; chk("wrap_pc", pc1, 32'hFFFF_FFFC); chk("wrap_r15", r151, 32'h4);
    chk("wrap_val", val1, 1); chk("restart_pc", pc0, 32'h100);
    rdy = 1;
    cyc(); chk("wrap_next", addr1, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
